verlet_node_bank: RTL and testbench

//  Time-multiplexed Verlet integrator for N_NODES cloth/rope nodes held in an internal register file.
//  On a start pulse it integrates every node once, in index order, at one node per cycle.
//  The per-node update covers gravity, damping, a floor clamp, the mouse impulse and a pin mask.
//  The constraint solver writes corrected positions back through a write port, and the renderer reads through a read port.

---
 rtl/verlet_pkg.sv | 22 ++
 rtl/verlet_node_update.sv | 71 +++++++
 rtl/verlet_node_bank.sv | 162 ++++++++++++++++
 tb/tb_verlet_node_bank.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verlet_pkg.sv
// Shared constants and FSM state type for the Verlet node bank.
package verlet_pkg;

  localparam int W    = 32;
  localparam int FRAC = 12;

  // Default physics constants in Q(W-FRAC).FRAC
  localparam logic signed [W-1:0] BASE_X_DEF      = W'(200 << FRAC);
  localparam logic signed [W-1:0] SPACING_DEF     = W'(10 << FRAC);
  localparam logic signed [W-1:0] GRAVITY_DEF     = W'('h4CD);
  localparam logic signed [W-1:0] MOUSE_POWER_DEF = W'(10 << FRAC);
  localparam logic signed [W-1:0] MOUSE_R_DEF     = W'(5 << FRAC);
  localparam logic signed [W-1:0] FLOOR_Y_DEF     = W'(500 << FRAC);
  localparam int                  DAMP_SHIFT_DEF  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/verlet_node_update.sv
// Combinational Verlet step for a single node: velocity from position history,
// optional damping, mouse impulse, gravity, floor clamp and pin hold.
module verlet_node_update #(
  parameter int                  W           = verlet_pkg::W,
  parameter logic signed [W-1:0] GRAVITY     = verlet_pkg::GRAVITY_DEF,
  parameter logic signed [W-1:0] MOUSE_POWER = verlet_pkg::MOUSE_POWER_DEF,
  parameter logic signed [W-1:0] MOUSE_R     = verlet_pkg::MOUSE_R_DEF,
  parameter logic signed [W-1:0] FLOOR_Y     = verlet_pkg::FLOOR_Y_DEF,
  parameter int                  DAMP_SHIFT  = verlet_pkg::DAMP_SHIFT_DEF
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] px_i,
  input  logic signed [W-1:0] py_i,
  input  logic signed [W-1:0] x_mouse_i,
  input  logic signed [W-1:0] y_mouse_i,
  input  logic                pin_i,
  output logic signed [W-1:0] nx_o,
  output logic signed [W-1:0] ny_o,
  output logic signed [W-1:0] npx_o,
  output logic signed [W-1:0] npy_o
);

  // Velocity damping v - (v >>> DAMP_SHIFT); a shift of 0 disables it.
  function automatic logic signed [W-1:0] damp(input logic signed [W-1:0] v);
    if (DAMP_SHIFT == 0) return v;
    return v - (v >>> DAMP_SHIFT);
  endfunction

  // True distance test |a-b| < MOUSE_R, using one extra bit so the
  // difference never wraps.
  function automatic logic near(input logic signed [W-1:0] a,
                                input logic signed [W-1:0] b);
    logic signed [W:0] d;
    d = $signed({a[W-1], a}) - $signed({b[W-1], b});
    if (d < 0) d = -d;
    return d < $signed({MOUSE_R[W-1], MOUSE_R});
  endfunction

  logic signed [W-1:0] vx;
  logic signed [W-1:0] vy;
  logic signed [W-1:0] imp;
  logic signed [W-1:0] ny_raw;
  logic                hit;

  // Next-state computation for one node
  always_comb begin
    vx     = damp(x_i - px_i);
    vy     = damp(y_i - py_i);
    hit    = near(x_i, x_mouse_i) && near(y_i, y_mouse_i);
    imp    = '0;
    if (hit) imp = (x_i >= x_mouse_i) ? MOUSE_POWER : -MOUSE_POWER;
    ny_raw = y_i + vy + GRAVITY;
    nx_o   = x_i + vx + imp;
    npx_o  = x_i;
    ny_o   = ny_raw;
    npy_o  = y_i;
    // Landing on the floor also kills vertical velocity
    if (ny_raw > FLOOR_Y) begin
      ny_o  = FLOOR_Y;
      npy_o = FLOOR_Y;
    end
    if (pin_i) begin
      nx_o  = x_i;
      ny_o  = y_i;
      npx_o = px_i;
      npy_o = py_i;
    end
  end

endmodule

// File: rtl/verlet_node_bank.sv
// Register file of N_NODES Verlet nodes with a one-node-per-cycle integration
// pass, a constraint write port (IDLE only) and a registered read port.
module verlet_node_bank #(
  parameter int                  N_NODES     = 8,
  parameter int                  W           = verlet_pkg::W,
  parameter logic signed [W-1:0] BASE_X      = verlet_pkg::BASE_X_DEF,
  parameter logic signed [W-1:0] SPACING     = verlet_pkg::SPACING_DEF,
  parameter logic signed [W-1:0] GRAVITY     = verlet_pkg::GRAVITY_DEF,
  parameter logic signed [W-1:0] MOUSE_POWER = verlet_pkg::MOUSE_POWER_DEF,
  parameter logic signed [W-1:0] MOUSE_R     = verlet_pkg::MOUSE_R_DEF,
  parameter int                  DAMP_SHIFT  = verlet_pkg::DAMP_SHIFT_DEF,
  parameter logic signed [W-1:0] FLOOR_Y     = verlet_pkg::FLOOR_Y_DEF,
  localparam int                 IDXW        = $clog2(N_NODES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic        [N_NODES-1:0]  pin,
  input  logic signed [W-1:0]        x_mouse,
  input  logic signed [W-1:0]        y_mouse,
  input  logic                       cst_we,
  input  logic        [IDXW-1:0]     cst_idx,
  input  logic signed [W-1:0]        cst_x,
  input  logic signed [W-1:0]        cst_y,
  output logic                       cst_ready,
  input  logic        [IDXW-1:0]     rd_idx,
  output logic signed [W-1:0]        rd_x,
  output logic signed [W-1:0]        rd_y
);
  import verlet_pkg::*;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NODES - 1);

  state_e              state_q;
  logic [IDXW-1:0]     idx_q;
  logic                busy_q;
  logic                done_q;
  logic                ready_q;

  logic signed [W-1:0] x_q  [N_NODES];
  logic signed [W-1:0] y_q  [N_NODES];
  logic signed [W-1:0] px_q [N_NODES];
  logic signed [W-1:0] py_q [N_NODES];

  logic signed [W-1:0] rd_x_q;
  logic signed [W-1:0] rd_y_q;

  logic signed [W-1:0] x_d;
  logic signed [W-1:0] y_d;
  logic signed [W-1:0] px_d;
  logic signed [W-1:0] py_d;

  logic                cst_take;
  logic                rd_ok;

  assign cst_take  = cst_we && ready_q && (int'(cst_idx) < N_NODES);
  assign rd_ok     = (int'(rd_idx) < N_NODES);
  assign busy      = busy_q;
  assign done      = done_q;
  assign cst_ready = ready_q;
  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;

  verlet_node_update #(
    .W           (W),
    .GRAVITY     (GRAVITY),
    .MOUSE_POWER (MOUSE_POWER),
    .MOUSE_R     (MOUSE_R),
    .FLOOR_Y     (FLOOR_Y),
    .DAMP_SHIFT  (DAMP_SHIFT)
  ) u_update (
    .x_i       (x_q[idx_q]),
    .y_i       (y_q[idx_q]),
    .px_i      (px_q[idx_q]),
    .py_i      (py_q[idx_q]),
    .x_mouse_i (x_mouse),
    .y_mouse_i (y_mouse),
    .pin_i     (pin[idx_q]),
    .nx_o      (x_d),
    .ny_o      (y_d),
    .npx_o     (px_d),
    .npy_o     (py_d)
  );

  // Pass sequencer: IDLE -> STEP (one node per cycle) -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= STEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        STEP: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Node storage: integration writes during STEP, constraint writes in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NODES; i++) begin
        x_q[i]  <= BASE_X;
        px_q[i] <= BASE_X;
        y_q[i]  <= SPACING * W'(i + 1);
        py_q[i] <= SPACING * W'(i + 1);
      end
    end else if (state_q == STEP) begin
      x_q[idx_q]  <= x_d;
      y_q[idx_q]  <= y_d;
      px_q[idx_q] <= px_d;
      py_q[idx_q] <= py_d;
    end else if (cst_take) begin
      x_q[cst_idx] <= cst_x;
      y_q[cst_idx] <= cst_y;
    end
  end

  // Registered read port, pre-edge contents, available in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_x_q <= '0;
      rd_y_q <= '0;
    end else begin
      rd_x_q <= rd_ok ? x_q[rd_idx] : '0;
      rd_y_q <= rd_ok ? y_q[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_verlet_node_bank.sv
// Bench for verlet_node_bank: directed scenarios plus randomized passes,
// compared against a per-node arithmetic model of the integrator.
module tb_verlet_node_bank;

  localparam int N       = 8;
  localparam int W       = 32;
  localparam int IDXW    = 3;
  localparam int BASE_X  = 'hC8000;
  localparam int SPACING = 'hA000;
  localparam int GRAV    = 'h4CD;
  localparam int MPOW    = 'hA000;
  localparam int MR      = 'h5000;
  localparam int FLOOR   = 'h1F4000;
  localparam int DS      = 0;
  localparam int FAR     = 32'h4000_0000;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                busy;
  logic                done;
  logic [N-1:0]        pin = '0;
  logic signed [W-1:0] x_mouse = FAR;
  logic signed [W-1:0] y_mouse = FAR;
  logic                cst_we = 1'b0;
  logic [IDXW-1:0]     cst_idx = '0;
  logic signed [W-1:0] cst_x = '0;
  logic signed [W-1:0] cst_y = '0;
  logic                cst_ready;
  logic [IDXW-1:0]     rd_idx = '0;
  logic signed [W-1:0] rd_x;
  logic signed [W-1:0] rd_y;

  always #5 clk = ~clk;

  verlet_node_bank dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pin       (pin),
    .x_mouse   (x_mouse),
    .y_mouse   (y_mouse),
    .cst_we    (cst_we),
    .cst_idx   (cst_idx),
    .cst_x     (cst_x),
    .cst_y     (cst_y),
    .cst_ready (cst_ready),
    .rd_idx    (rd_idx),
    .rd_x      (rd_x),
    .rd_y      (rd_y)
  );

  // Reference state: one entry per node, plain 32-bit wrapping integers
  int mx [N];
  int my [N];
  int mpx[N];
  int mpy[N];

  int vectors = 0;
  int fails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]  = BASE_X;
      mpx[i] = BASE_X;
      my[i]  = (i + 1) * SPACING;
      mpy[i] = (i + 1) * SPACING;
    end
  endfunction

  function automatic bit in_box(input int a, input int b);
    longint d;
    d = longint'(a) - longint'(b);
    if (d < 0) d = -d;
    return d < longint'(MR);
  endfunction

  function automatic void model_pass(input logic [N-1:0] p, input int xm, input int ym);
    int vx, vy, imp, nx, ny;
    for (int i = 0; i < N; i++) begin
      if (!p[i]) begin
        vx = mx[i] - mpx[i];
        vy = my[i] - mpy[i];
        if (DS != 0) begin
          vx = vx - (vx >>> DS);
          vy = vy - (vy >>> DS);
        end
        imp = 0;
        if (in_box(mx[i], xm) && in_box(my[i], ym)) imp = (mx[i] >= xm) ? MPOW : -MPOW;
        nx = mx[i] + vx + imp;
        ny = my[i] + vy + GRAV;
        mpx[i] = mx[i];
        if (ny > FLOOR) begin
          ny = FLOOR;
          mpy[i] = FLOOR;
        end else begin
          mpy[i] = my[i];
        end
        mx[i] = nx;
        my[i] = ny;
      end
    end
  endfunction

  task automatic read_node(input int i, output logic [31:0] rx, output logic [31:0] ry);
    @(negedge clk);
    rd_idx = IDXW'(i);
    @(negedge clk);
    rx = rd_x;
    ry = rd_y;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] rx, ry;
    for (int i = 0; i < N; i++) begin
      read_node(i, rx, ry);
      check($sformatf("%s_x%0d", tag, i), rx, mx[i]);
      check($sformatf("%s_y%0d", tag, i), ry, my[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    cst_we = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", cst_ready, 1'b1);
    check("rst_rdx", rd_x, 0);
    check("rst_rdy", rd_y, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // One pass, optionally with a constraint write in the start cycle and
  // optionally disturbed mid-pass by a dropped write and an ignored start.
  task automatic run_pass(input logic [N-1:0] p, input int xm, input int ym,
                          input bit we, input int wi, input int wx, input int wy,
                          input bit disturb);
    int k;
    int dones;
    @(negedge clk);
    pin = p;
    x_mouse = xm;
    y_mouse = ym;
    start = 1'b1;
    cst_we = we;
    cst_idx = IDXW'(wi);
    cst_x = wx;
    cst_y = wy;
    @(negedge clk);
    start = 1'b0;
    cst_we = 1'b0;
    k = 1;
    check("pass_busy", busy, 1'b1);
    check("pass_not_ready", cst_ready, 1'b0);
    while (done !== 1'b1 && k < 40) begin
      if (disturb && k == 3) begin
        cst_we = 1'b1;
        cst_idx = 3'd2;
        cst_x = $urandom;
        cst_y = $urandom;
        start = 1'b1;
      end else begin
        cst_we = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    cst_we = 1'b0;
    start = 1'b0;
    check("done_latency", k, N + 1);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_ready", cst_ready, 1'b1);
    if (we) begin
      mx[wi] = wx;
      my[wi] = wy;
    end
    model_pass(p, xm, ym);
    if (disturb) begin
      dones = 0;
      repeat (12) begin
        @(negedge clk);
        if (done) dones++;
      end
      check("no_second_done", dones, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx, ry;
    logic [N-1:0] p;
    int j, xm, ym, wi, wx, wy, dones;
    bit we;

    // Reset state
    do_reset();
    check_all("reset");
    read_node(0, rx, ry);
    check("n0_reset_x", rx, 'hC8000);
    check("n0_reset_y", ry, 'hA000);
    read_node(7, rx, ry);
    check("n7_reset_y", ry, 'h50000);

    // Two free-fall passes
    run_pass('0, FAR, FAR, 0, 0, 0, 0, 0);
    check_all("fall1");
    read_node(0, rx, ry);
    check("n0_fall1_x", rx, 'hC8000);
    check("n0_fall1_y", ry, 'hA4CD);
    run_pass('0, FAR, FAR, 0, 0, 0, 0, 0);
    check_all("fall2");
    read_node(0, rx, ry);
    check("n0_fall2_y", ry, 'hAE67);

    // Pinned node 0
    do_reset();
    run_pass(8'h01, FAR, FAR, 0, 0, 0, 0, 0);
    check_all("pin");
    read_node(0, rx, ry);
    check("pin_n0_x", rx, 'hC8000);
    check("pin_n0_y", ry, 'hA000);
    read_node(1, rx, ry);
    check("pin_n1_y", ry, 'h144CD);

    // Mouse impulse on node 0 only
    do_reset();
    run_pass('0, 'hC9000, 'hA000, 0, 0, 0, 0, 0);
    check_all("mouse");
    read_node(0, rx, ry);
    check("mouse_n0_x", rx, 'hBE000);
    read_node(1, rx, ry);
    check("mouse_n1_x", rx, 'hC8000);

    // Write and start attempted during STEP: both have no effect
    do_reset();
    run_pass('0, FAR, FAR, 0, 0, 0, 0, 1);
    check_all("disturb");

    // IDLE constraint write below the floor, then a pass clamps it
    do_reset();
    @(negedge clk);
    cst_we = 1'b1;
    cst_idx = 3'd3;
    cst_x = 'hC8000;
    cst_y = 'h1F5000;
    @(negedge clk);
    cst_we = 1'b0;
    mx[3] = 'hC8000;
    my[3] = 'h1F5000;
    check_all("cst");
    run_pass('0, FAR, FAR, 0, 0, 0, 0, 0);
    check_all("floor");
    read_node(3, rx, ry);
    check("floor_n3_y", ry, 'h1F4000);

    // Write coinciding with start lands before the pass
    run_pass('0, FAR, FAR, 1, 5, 'hD0000, 'h30000, 0);
    check_all("wr_start");

    // Reset while idx=4: pass aborted, no done
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", cst_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    reset = 1'b0;
    model_reset();
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check_all("abort");

    // Randomized passes: mouse near a node, random pins and writes
    for (int r = 0; r < 8; r++) begin
      p  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      j  = $urandom_range(0, N - 1);
      xm = mx[j] + int'($urandom_range(0, 'hC000)) - 'h6000;
      ym = my[j] + int'($urandom_range(0, 'hC000)) - 'h6000;
      we = 1'($urandom_range(0, 1));
      wi = $urandom_range(0, N - 1);
      wx = mx[wi] + int'($urandom_range(0, 'h4000)) - 'h2000;
      wy = (r == 5) ? FLOOR + 'h100 : my[wi] + int'($urandom_range(0, 'h4000)) - 'h2000;
      run_pass(p, xm, ym, we, wi, wx, wy, 0);
      check_all($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
